// File: rtl/layer_scheduler_if.sv
// Image stream between the upstream source, the scheduler and the layers block.
// master: the scheduler side; slave: the environment driving src and consuming image.
interface layer_scheduler_if #(
    parameter int unsigned DWIDTH = 64
);
    logic [DWIDTH-1:0] src_data;
    logic              src_val;
    logic              src_rdy;
    logic [DWIDTH-1:0] image_bus;
    logic              image_last;
    logic              image_val;
    logic              image_rdy;

    modport master (
        input  src_data, src_val, image_rdy,
        output src_rdy, image_bus, image_last, image_val
    );

    modport slave (
        output src_data, src_val, image_rdy,
        input  src_rdy, image_bus, image_last, image_val
    );
endinterface

// File: rtl/layer_scheduler.sv
// Sequences one convolution pass: gates the image stream, drives kernel addresses, counts results.
// Optional feature: define LAYER_SCHED_STALL_CNT_EN to add the stall_cnt output.
module layer_scheduler #(
    parameter int unsigned            CFG_DWIDTH  = 32,
    parameter int unsigned            CFG_AWIDTH  = 5,
    parameter logic [CFG_AWIDTH-1:0]  CFG_ADDR    = CFG_AWIDTH'(6),
    parameter int unsigned            GROUP_NB    = 4,
    parameter int unsigned            IMG_WIDTH   = 16,
    parameter int unsigned            KADDR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CFG_DWIDTH-1:0]  cfg_data,
    input  logic [CFG_AWIDTH-1:0]  cfg_addr,
    input  logic                   cfg_valid,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    layer_scheduler_if.master      img,
    output logic [KADDR_WIDTH-1:0] ker_addr,
    input  logic                   result_val,
    input  logic                   result_rdy
`ifdef LAYER_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);

    localparam int unsigned BUS_W  = GROUP_NB * IMG_WIDTH;
    localparam int unsigned BEAT_W = 8;
    localparam int unsigned ACC_W  = 8;
    localparam int unsigned OUT_W  = 16;
    localparam int unsigned RES_W  = 16;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_RUN   = 4'b0010,
        S_DRAIN = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    state_t            state;
    logic [31:0]       setup;
    logic [BEAT_W-1:0] sh_beats;
    logic [ACC_W-1:0]  sh_pool_nb;
    logic [OUT_W-1:0]  sh_out_nb;
    logic [BEAT_W-1:0] beat_cnt;
    logic [ACC_W-1:0]  acc_cnt;
    logic [OUT_W-1:0]  out_cnt;
    logic [RES_W-1:0]  res_cnt;

    logic [BEAT_W-1:0] beats_eff;
    logic              run_act;
    logic              last_beat;
    logic              last_acc;
    logic              last_out;
    logic              beat_hs;
    logic              res_hs;
    logic [RES_W:0]    res_total;
    logic              res_all;

    // A pass with out_nb == 0 spends its single RUN cycle with the stream gated off.
    assign beats_eff = (sh_beats == '0) ? BEAT_W'(1) : sh_beats;
    assign run_act   = (state == S_RUN) && (sh_out_nb != '0);
    assign last_beat = (beat_cnt == beats_eff - BEAT_W'(1));
    assign last_acc  = (acc_cnt == sh_pool_nb);
    assign last_out  = (out_cnt == sh_out_nb - OUT_W'(1));
    assign beat_hs   = run_act && img.src_val && img.image_rdy;
    assign res_hs    = ((state == S_RUN) || (state == S_DRAIN)) && result_val && result_rdy;
    assign res_total = {1'b0, res_cnt} + (RES_W + 1)'(res_hs);
    assign res_all   = (res_total >= {1'b0, sh_out_nb});

    assign img.image_bus  = BUS_W'(img.src_data);
    assign img.image_val  = run_act && img.src_val;
    assign img.src_rdy    = run_act && img.image_rdy;
    assign img.image_last = run_act && last_beat;
    assign ker_addr       = run_act ? KADDR_WIDTH'(beat_cnt) : '0;
    assign busy           = (state == S_RUN) || (state == S_DRAIN);
    assign done           = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            setup      <= '0;
            sh_beats   <= '0;
            sh_pool_nb <= '0;
            sh_out_nb  <= '0;
            beat_cnt   <= '0;
            acc_cnt    <= '0;
            out_cnt    <= '0;
            res_cnt    <= '0;
`ifdef LAYER_SCHED_STALL_CNT_EN
            stall_cnt  <= '0;
`endif
        end else begin
            if (cfg_valid && (cfg_addr == CFG_ADDR)) begin
                setup <= 32'(cfg_data);
            end

            if (res_hs) begin
                res_cnt <= res_cnt + RES_W'(1);
            end

            // beat -> accumulation -> pooled output cascade
            if (beat_hs) begin
                if (last_beat) begin
                    beat_cnt <= '0;
                    if (last_acc) begin
                        acc_cnt <= '0;
                        out_cnt <= out_cnt + OUT_W'(1);
                    end else begin
                        acc_cnt <= acc_cnt + ACC_W'(1);
                    end
                end else begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                end
            end

`ifdef LAYER_SCHED_STALL_CNT_EN
            if (run_act && img.src_val && !img.image_rdy && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
`endif

            case (state)
                S_IDLE: begin
                    if (start) begin
                        sh_beats   <= setup[7:0];
                        sh_pool_nb <= setup[15:8];
                        sh_out_nb  <= setup[31:16];
                        beat_cnt   <= '0;
                        acc_cnt    <= '0;
                        out_cnt    <= '0;
                        res_cnt    <= '0;
`ifdef LAYER_SCHED_STALL_CNT_EN
                        stall_cnt  <= '0;
`endif
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (sh_out_nb == '0) begin
                        state <= S_DONE;
                    end else if (beat_hs && last_beat && last_acc && last_out) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (res_all) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_scheduler.sv
// Randomized self-checking bench for layer_scheduler against a beat-index reference model.
module tb_layer_scheduler;

    localparam int unsigned DW = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_data;
    logic [4:0]  cfg_addr;
    logic        cfg_valid;
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  ker_addr;
    logic        result_val;
    logic        result_rdy;
`ifdef LAYER_SCHED_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    layer_scheduler_if #(.DWIDTH(DW)) img_if ();

    layer_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_data   (cfg_data),
        .cfg_addr   (cfg_addr),
        .cfg_valid  (cfg_valid),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .img        (img_if),
        .ker_addr   (ker_addr),
        .result_val (result_val),
        .result_rdy (result_rdy)
`ifdef LAYER_SCHED_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: phase 0 idle, 1 run, 2 drain, 3 done; m_k counts accepted beats
    int          m_phase = 0;
    int          m_k = 0, m_res = 0, m_b = 1, m_p = 0, m_n = 0, m_total = 0;
    logic [31:0] m_setup = '0;
    logic [31:0] m_stall = '0;

    bit          nxt_cv = 1'b0;
    logic [4:0]  nxt_ca = '0;
    logic [31:0] nxt_cd = '0;
    logic [DW-1:0] drv_data;
    bit          obs_hs, obs_last, obs_done;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] setup_word(input int b, input int p, input int n);
        return {16'(n), 8'(p), 8'(b)};
    endfunction

    task automatic cycle(input bit st, input bit sv, input bit ir, input bit rv, input bit rr);
        bit active, hs, rhs;
        int ph;
        @(posedge clk);
        #1;
        rst              = 1'b0;
        start            = st;
        img_if.src_val   = sv;
        img_if.image_rdy = ir;
        result_val       = rv;
        result_rdy       = rr;
        drv_data         = {$urandom, $urandom};
        img_if.src_data  = drv_data;
        cfg_valid        = nxt_cv;
        cfg_addr         = nxt_ca;
        cfg_data         = nxt_cd;
        nxt_cv           = 1'b0;
        @(negedge clk);
        active = (m_phase == 1) && (m_n != 0);
        check_eq("busy", 64'(busy), 64'((m_phase == 1) || (m_phase == 2)));
        check_eq("done", 64'(done), 64'(m_phase == 3));
        check_eq("src_rdy", 64'(img_if.src_rdy), 64'(active && ir));
        check_eq("image_val", 64'(img_if.image_val), 64'(active && sv));
        check_eq("image_last", 64'(img_if.image_last), 64'(active && ((m_k % m_b) == m_b - 1)));
        check_eq("ker_addr", 64'(ker_addr), active ? 64'(m_k % m_b) : 64'd0);
        check_eq("image_bus", 64'(img_if.image_bus), 64'(drv_data));
`ifdef LAYER_SCHED_STALL_CNT_EN
        check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
        obs_hs   = img_if.src_val && img_if.src_rdy;
        obs_last = obs_hs && img_if.image_last;
        obs_done = done;

        ph  = m_phase;
        hs  = active && sv && ir;
        rhs = ((ph == 1) || (ph == 2)) && rv && rr;
        if (active && sv && !ir && (m_stall != 32'hFFFF_FFFF)) m_stall++;
        case (ph)
            0: if (st) begin
                m_b     = (m_setup[7:0] == 8'd0) ? 1 : int'(m_setup[7:0]);
                m_p     = int'(m_setup[15:8]);
                m_n     = int'(m_setup[31:16]);
                m_total = m_b * (m_p + 1) * m_n;
                m_k     = 0;
                m_res   = 0;
                m_stall = '0;
                m_phase = 1;
            end
            1: if (m_n == 0) m_phase = 3;
               else if (hs && (m_k + 1 == m_total)) m_phase = 2;
            2: if (m_res + int'(rhs) >= m_n) m_phase = 3;
            default: m_phase = 0;
        endcase
        if (rhs) m_res++;
        if (hs) m_k++;
        if (cfg_valid && (cfg_addr == 5'd6)) m_setup = cfg_data;
    endtask

    task automatic write_cfg(input logic [4:0] a, input logic [31:0] d);
        nxt_cv = 1'b1;
        nxt_ca = a;
        nxt_cd = d;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b0; img_if.src_val = 1'b0; img_if.image_rdy = 1'b0;
        result_val = 1'b0; result_rdy = 1'b0; cfg_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_src_rdy", 64'(img_if.src_rdy), 64'd0);
        check_eq("rst_image_val", 64'(img_if.image_val), 64'd0);
        check_eq("rst_image_last", 64'(img_if.image_last), 64'd0);
        check_eq("rst_ker_addr", 64'(ker_addr), 64'd0);
`ifdef LAYER_SCHED_STALL_CNT_EN
        check_eq("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        m_phase = 0; m_setup = '0; m_stall = '0; m_k = 0; m_res = 0; m_b = 1; m_n = 0;
    endtask

    task automatic run_to_idle(input int vp, input int rp, input int resp, input bit drain_only,
                               input bit noise, output int hs, output int lasts,
                               output int dones, output int done_at);
        hs = 0; lasts = 0; dones = 0; done_at = -1;
        for (int i = 0; i < 3000; i++) begin
            bit rv, st;
            if (m_phase == 0) break;
            rv = (int'($urandom_range(99)) < resp) && (!drain_only || (m_phase == 2));
            st = noise && ($urandom_range(9) == 0);
            if (noise && ($urandom_range(19) == 0)) begin
                nxt_cv = 1'b1;
                nxt_ca = 5'($urandom_range(31));
                nxt_cd = setup_word(int'($urandom_range(4)), 0, 1);
            end
            cycle(st, int'($urandom_range(99)) < vp, int'($urandom_range(99)) < rp, rv,
                  (noise ? ($urandom_range(3) != 0) : 1'b1));
            hs    += int'(obs_hs);
            lasts += int'(obs_last);
            if (obs_done) begin
                dones++;
                if (done_at < 0) done_at = i;
            end
        end
        check_eq("pass_ends", 64'(m_phase == 0), 64'd1);
    endtask

    initial begin
        int hs, lasts, dones, done_at;
        rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        result_val = 1'b0; result_rdy = 1'b0;
        img_if.src_val = 1'b0; img_if.image_rdy = 1'b0; img_if.src_data = '0;
        do_reset();

        // beats=9, single accumulation per output, two outputs
        write_cfg(5'd6, setup_word(9, 0, 2));
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_to_idle(100, 100, 20, 1'b0, 1'b0, hs, lasts, dones, done_at);
        check_eq("t1_beats", 64'(hs), 64'd18);
        check_eq("t1_lasts", 64'(lasts), 64'd2);
        check_eq("t1_dones", 64'(dones), 64'd1);

        // beats=4, pool of 4, one output; result only while draining
        write_cfg(5'd6, setup_word(4, 3, 1));
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_to_idle(100, 100, 40, 1'b1, 1'b0, hs, lasts, dones, done_at);
        check_eq("t2_beats", 64'(hs), 64'd16);
        check_eq("t2_lasts", 64'(lasts), 64'd4);
        check_eq("t2_dones", 64'(dones), 64'd1);

        // out_nb=0: no beats, done on the second cycle after start is taken
        write_cfg(5'd6, setup_word(3, 0, 0));
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_to_idle(100, 100, 50, 1'b0, 1'b0, hs, lasts, dones, done_at);
        check_eq("t3_beats", 64'(hs), 64'd0);
        check_eq("t3_done_at", 64'(done_at), 64'd1);

        // five-cycle downstream stall after three beats
        write_cfg(5'd6, setup_word(9, 0, 1));
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t4_kaddr_hold", 64'(ker_addr), 64'd3);
        run_to_idle(100, 100, 50, 1'b0, 1'b0, hs, lasts, dones, done_at);
        check_eq("t4_beats_after", 64'(hs), 64'd6);
`ifdef LAYER_SCHED_STALL_CNT_EN
        check_eq("t4_stall_total", 64'(stall_cnt), 64'd5);
`endif

        // reset mid-pass, then a clean pass
        write_cfg(5'd6, setup_word(9, 0, 1));
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        write_cfg(5'd6, setup_word(9, 0, 1));
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_to_idle(100, 100, 30, 1'b0, 1'b0, hs, lasts, dones, done_at);
        check_eq("t5_beats", 64'(hs), 64'd9);
        check_eq("t5_dones", 64'(dones), 64'd1);

        // setup rewritten mid-pass only affects the following pass
        write_cfg(5'd6, setup_word(9, 0, 1));
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        write_cfg(5'd6, setup_word(2, 0, 1));
        run_to_idle(100, 100, 30, 1'b0, 1'b0, hs, lasts, dones, done_at);
        check_eq("t6_old_beats", 64'(hs + 2), 64'd9);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_to_idle(100, 100, 30, 1'b0, 1'b0, hs, lasts, dones, done_at);
        check_eq("t6_new_beats", 64'(hs), 64'd2);

        // random passes with background noise on config, start and handshakes
        for (int n = 0; n < 40; n++) begin
            int b, p, o;
            b = int'($urandom_range(5));
            p = int'($urandom_range(2));
            o = int'($urandom_range(3));
            write_cfg(5'd6, setup_word(b, p, o));
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            run_to_idle(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                        int'($urandom_range(80, 20)), 1'b0, 1'b1, hs, lasts, dones, done_at);
            check_eq("rnd_beats", 64'(hs), 64'(((b == 0) ? 1 : b) * (p + 1) * o));
            check_eq("rnd_dones", 64'(dones), 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
